// File: rtl/crc_frame_receiver_pkg.sv
// Shared types and constants for the serial CRC frame receiver.
// Holds the word tag encodings, receiver state encoding and default word geometry.
package crc_frame_receiver_pkg;

  localparam int         DEF_MESS_LEN = 10;
  localparam int         DEF_CRC_LEN  = 4;
  localparam logic [4:0] DEF_POLY     = 5'b10011;

  localparam logic [1:0] TAG_FIRST = 2'b01;
  localparam logic [1:0] TAG_MID   = 2'b10;
  localparam logic [1:0] TAG_LAST  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    WRITE,
    DRAIN
  } rx_state_e;

  // Tag a word must carry, given its position in the frame.
  function automatic logic [1:0] expected_tag(input int idx, input int nbr_words);
    if (idx == 0) begin
      return TAG_FIRST;
    end else if (idx == nbr_words - 1) begin
      return TAG_LAST;
    end else begin
      return TAG_MID;
    end
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/crc_frame_receiver_crc4_serial_check.sv
// Serial CRC remainder register: divides the bit stream by POLY one bit at a time.
// A zero remainder after the whole {msg,crc} field means the word is intact.
module crc4_serial_check
  import crc_frame_receiver_pkg::*;
#(
  parameter int               CRC_LEN = DEF_CRC_LEN,
  parameter logic [CRC_LEN:0] POLY    = DEF_POLY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic shift,
  input  logic bit_in,
  output logic zero
);

  logic [CRC_LEN-1:0] remainder;

  // When the bit shifted out is set, the divisor's leading term cancels it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remainder <= '0;
    end else if (clear) begin
      remainder <= '0;
    end else if (shift) begin
      remainder <= {remainder[CRC_LEN-2:0], bit_in}
                   ^ (remainder[CRC_LEN-1] ? POLY[CRC_LEN-1:0] : '0);
    end
  end

  assign zero = (remainder == '0);

endmodule

// File: rtl/crc_frame_receiver.sv
// Receives tagged, CRC-protected words from an asynchronous serial line and writes
// the good ones to memory, reporting per-word errors and a per-frame result.
module crc_frame_receiver
  import crc_frame_receiver_pkg::*;
#(
  parameter int               MESS_LEN  = DEF_MESS_LEN,
  parameter int               CRC_LEN   = DEF_CRC_LEN,
  parameter logic [CRC_LEN:0] POLY      = DEF_POLY,
  parameter int               NBR_WORDS = 14,
  parameter int unsigned      ADDR_INIT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ser_data,
  input  logic                         ser_clk,
  input  logic                         ser_en,
  output logic [4:0]                   address,
  output logic                         wren,
  output logic [MESS_LEN+CRC_LEN+1:0]  wr_data,
  output logic                         frame_done,
  output logic                         crc_err,
  output logic                         tag_err,
  output logic                         frame_ok,
  output logic [7:0]                   err_cnt,
  output logic                         busy
);

  localparam int WORD_LEN = MESS_LEN + CRC_LEN + 2;
  localparam int BCW      = $clog2(WORD_LEN + 1);
  localparam int IDXW     = (NBR_WORDS > 1) ? $clog2(NBR_WORDS) : 1;

  localparam logic [BCW-1:0]  BITS_LAST = BCW'(WORD_LEN - 1);
  localparam logic [BCW-1:0]  TAG_BITS  = BCW'(2);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NBR_WORDS - 1);
  localparam logic [4:0]      ADDR_BASE = ADDR_INIT[4:0];

  logic data_meta, data_s;
  logic sclk_meta, sclk_s, sclk_s_d;
  logic en_meta, en_s, en_s_d;
  logic sample, en_rise;

  rx_state_e state, state_next;

  logic [WORD_LEN-1:0] shift_reg;
  logic [BCW-1:0]      bit_cnt;
  logic [IDXW-1:0]     word_idx;

  logic start_frame, take_bit, abort_frame, check_word, write_step, end_frame;
  logic crc_zero, crc_fail, tag_fail, last_word;
  logic crc_clear, crc_shift;

  // The line clock is only ever used as data: its synchronized rising edge marks a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_meta <= 1'b0;
      data_s    <= 1'b0;
      sclk_meta <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_s_d  <= 1'b0;
      en_meta   <= 1'b0;
      en_s      <= 1'b0;
      en_s_d    <= 1'b0;
    end else begin
      data_meta <= ser_data;
      data_s    <= data_meta;
      sclk_meta <= ser_clk;
      sclk_s    <= sclk_meta;
      sclk_s_d  <= sclk_s;
      en_meta   <= ser_en;
      en_s      <= en_meta;
      en_s_d    <= en_s;
    end
  end

  assign sample  = sclk_s & ~sclk_s_d;
  assign en_rise = en_s & ~en_s_d;

  assign last_word = (word_idx == IDX_LAST);
  assign crc_fail  = ~crc_zero;
  assign tag_fail  = (shift_reg[WORD_LEN-1 -: 2] != expected_tag(int'(word_idx), NBR_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    take_bit    = 1'b0;
    abort_frame = 1'b0;
    check_word  = 1'b0;
    write_step  = 1'b0;
    end_frame   = 1'b0;
    case (state)
      IDLE: begin
        if (en_rise) begin
          start_frame = 1'b1;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (!en_s) begin
          abort_frame = 1'b1;
          state_next  = IDLE;
        end else if (sample) begin
          take_bit = 1'b1;
          if (bit_cnt == BITS_LAST) begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        check_word = 1'b1;
        state_next = tag_fail ? DRAIN : WRITE;
      end
      WRITE: begin
        write_step = 1'b1;
        state_next = last_word ? IDLE : SHIFT;
      end
      DRAIN: begin
        if (!en_s) begin
          end_frame  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The two tag bits lead each word but are not covered by the CRC.
  assign crc_clear = (state != SHIFT);
  assign crc_shift = take_bit && (bit_cnt >= TAG_BITS);

  crc4_serial_check #(
    .CRC_LEN (CRC_LEN),
    .POLY    (POLY)
  ) u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (crc_clear),
    .shift  (crc_shift),
    .bit_in (data_s),
    .zero   (crc_zero)
  );

  // Write strobe and error pulses are registered at the end of CHECK so they
  // line up with the WRITE cycle and the address of the word just checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      word_idx   <= '0;
      address    <= ADDR_BASE;
      wren       <= 1'b0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      crc_err    <= 1'b0;
      tag_err    <= 1'b0;
      frame_ok   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      wren       <= 1'b0;
      frame_done <= 1'b0;
      crc_err    <= 1'b0;
      tag_err    <= 1'b0;
      if (start_frame) begin
        word_idx <= '0;
        bit_cnt  <= '0;
        frame_ok <= 1'b1;
        address  <= ADDR_BASE;
      end
      if (take_bit) begin
        shift_reg <= {shift_reg[WORD_LEN-2:0], data_s};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (abort_frame) begin
        tag_err    <= 1'b1;
        frame_ok   <= 1'b0;
        frame_done <= 1'b1;
        err_cnt    <= sat_add8(err_cnt, 2'd1);
        address    <= ADDR_BASE;
      end
      if (check_word) begin
        crc_err <= crc_fail;
        tag_err <= tag_fail;
        err_cnt <= sat_add8(err_cnt, {1'b0, crc_fail} + {1'b0, tag_fail});
        if (crc_fail || tag_fail) begin
          frame_ok <= 1'b0;
        end else begin
          wren    <= 1'b1;
          wr_data <= shift_reg;
        end
      end
      if (write_step) begin
        bit_cnt  <= '0;
        word_idx <= word_idx + 1'b1;
        if (last_word) begin
          frame_done <= 1'b1;
          address    <= ADDR_BASE;
        end else begin
          address <= address + 5'd1;
        end
      end
      if (end_frame) begin
        frame_done <= 1'b1;
        address    <= ADDR_BASE;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
